// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: hex decode, leading-zero
// suppression and per-digit blink, with registered seg/an outputs.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 4096,
   parameter int BLINK_FRAMES = 64,
   parameter bit ACTIVE_LOW   = 1'b1,
   localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_tick
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SCAN_W-1:0]     SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
   localparam logic [6:0]            SEG_OFF    = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

   typedef enum logic {
      PH_VISIBLE = 1'b0,
      PH_HIDDEN  = 1'b1
   } phase_t;

   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [SCAN_W-1:0]       r_scan_cnt;
   logic [IDX_W-1:0]        r_digit_idx;
   logic [BLINK_W-1:0]      r_blink_cnt;
   phase_t                  r_phase;
   logic                    r_frame_tick;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_an;

   logic                    w_scan_tc;
   logic                    w_frame_wrap;
   logic [NUM_DIGITS-1:0]   w_blank;
   logic [NUM_DIGITS-1:0]   w_an_sel;
   logic [3:0]              w_nibble;
   logic                    w_dig_blank;

   // Patterns are written low-active {g,f,e,d,c,b,a}; inverted for high-active boards.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'h0:    p = 7'b1000000;
         4'h1:    p = 7'b1111001;
         4'h2:    p = 7'b0100100;
         4'h3:    p = 7'b0110000;
         4'h4:    p = 7'b0011001;
         4'h5:    p = 7'b0010010;
         4'h6:    p = 7'b0000010;
         4'h7:    p = 7'b1111000;
         4'h8:    p = 7'b0000000;
         4'h9:    p = 7'b0010000;
         4'hA:    p = 7'b0001000;
         4'hB:    p = 7'b0000011;
         4'hC:    p = 7'b1000110;
         4'hD:    p = 7'b0100001;
         4'hE:    p = 7'b0000110;
         default: p = 7'b0001110;
      endcase
      return ACTIVE_LOW ? p : ~p;
   endfunction

   assign w_scan_tc    = (r_scan_cnt == SCAN_LAST);
   assign w_frame_wrap = w_scan_tc && (r_digit_idx == IDX_LAST);

   // A digit is blanked when it and every higher digit are zero (never digit 0),
   // or when it is masked during the hidden blink phase.
   always_comb begin
      logic v_all_zero;
      // NOTE: every combinational output gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      w_blank    = '0;
      v_all_zero = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         v_all_zero = 1'b1;
         for (int j = i; j < NUM_DIGITS; j++) begin
            v_all_zero = v_all_zero && (r_shadow[4*j +: 4] == 4'h0);
         end
         w_blank[i] = (blank_lz && v_all_zero && (i != 0)) ||
                      ((r_phase == PH_HIDDEN) && blink_mask[i]);
      end
   end

   always_comb begin
      w_nibble    = 4'h0;
      w_dig_blank = 1'b0;
      w_an_sel    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_digit_idx == IDX_W'(i)) begin
            w_nibble    = r_shadow[4*i +: 4];
            w_dig_blank = w_blank[i];
            w_an_sel[i] = 1'b1;
         end
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register samples
   // the pre-edge values; that is what lets a load on a slot change still show the old digit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow     <= '0;
         r_scan_cnt   <= '0;
         r_digit_idx  <= '0;
         r_blink_cnt  <= '0;
         r_phase      <= PH_VISIBLE;
         r_frame_tick <= 1'b0;
         r_seg        <= SEG_OFF;
         r_an         <= AN_OFF;
      end else begin
         if (load) begin
            r_shadow <= digits_in;
         end

         r_seg        <= w_dig_blank ? SEG_OFF : hex_to_seg(w_nibble);
         r_an         <= w_an_sel ^ AN_OFF;
         r_frame_tick <= w_frame_wrap;

         if (w_scan_tc) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end

         if (w_frame_wrap) begin
            if (r_blink_cnt == BLINK_LAST) begin
               r_blink_cnt <= '0;
               r_phase     <= (r_phase == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
            end else begin
               r_blink_cnt <= r_blink_cnt + 1'b1;
            end
         end
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign digit_idx  = r_digit_idx;
   assign frame_tick = r_frame_tick;

endmodule
